file_register_ctrl: RTL and testbench

FILE_REGISTER_CTRL -- requirements
Module: file_register_ctrl

---
 rtl/file_register_ctrl.sv | 121 ++++++++++++
 tb/tb_file_register_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/file_register_ctrl.sv
// file_register_ctrl: arbitrates two write requesters (ALU writeback, memory
// load) onto a single register-file write port and runs a clear sequence that
// zeroes registers 1..N-1. All state changes on the falling clock edge,
// the edge on which the register file samples its write port.
// Optional feature: define FILE_REGISTER_RR_EN for round-robin arbitration;
// otherwise requester A has fixed priority and no history flop exists.
module file_register_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  req_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  ack_a,
  output logic                  ack_b,
  input  logic                  clear_req,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  clear_done
);

  typedef enum logic {RUN, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = {ADDR_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  done_q, done_d;
`ifdef FILE_REGISTER_RR_EN
  // High when A won the most recent grant, so B is favoured next.
  logic                  last_a_q, last_a_d;
`endif

  // State, clear pointer, done pulse and arbitration history registers.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      ptr_q    <= PTR_FIRST;
      done_q   <= 1'b0;
`ifdef FILE_REGISTER_RR_EN
      last_a_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
`ifdef FILE_REGISTER_RR_EN
      last_a_q <= last_a_d;
`endif
    end
  end

  // Arbitration, write-port steering and next-state logic.
  always_comb begin
    ack_a   = 1'b0;
    ack_b   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
`ifdef FILE_REGISTER_RR_EN
    last_a_d = last_a_q;
`endif
    case (state_q)
      RUN: begin
`ifdef FILE_REGISTER_RR_EN
        if (req_a && req_b) begin
          ack_a = !last_a_q;
          ack_b = last_a_q;
        end else begin
          ack_a = req_a;
          ack_b = req_b;
        end
        if (ack_a) last_a_d = 1'b1;
        if (ack_b) last_a_d = 1'b0;
`else
        ack_a = req_a;
        ack_b = req_b && !req_a;
`endif
        // r0 is hardwired zero: the grant completes but nothing is written.
        if (ack_a) begin
          wr_addr = addr_a;
          wr_data = data_a;
          wr_en   = |addr_a;
        end else if (ack_b) begin
          wr_addr = addr_b;
          wr_data = data_b;
          wr_en   = |addr_b;
        end
        // A grant in this same cycle still completes at this edge.
        if (clear_req) state_d = CLEAR;
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        if (ptr_q == PTR_LAST) begin
          state_d = RUN;
          ptr_d   = PTR_FIRST;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign busy       = (state_q == CLEAR);
  assign clear_done = done_q;

endmodule

// File: tb/tb_file_register_ctrl.sv
// Testbench for file_register_ctrl: directed scenarios followed by randomized
// traffic, every cycle checked against a transaction-level reference model.
module tb_file_register_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset, req_a, req_b, clear_req;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          ack_a, ack_b, wr_en, busy, clear_done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int tests = 0;
  int fails = 0;

  file_register_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .clear_req(clear_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  // Reference model: clearing flag, next address to be cleared, pending
  // done pulse, and who was granted most recently.
  bit m_clearing;
  int m_clr_addr;
  bit m_done;
  bit m_last_b;
  // Expected per-cycle values and a snapshot of what the DUT showed.
  bit e_ack_a, e_ack_b;
  bit s_ack_a, s_ack_b, s_wr_en, s_busy, s_done;
  int s_wr_addr;
  bit a_taken, b_taken;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: inputs already driven; check outputs before the falling edge,
  // then advance the model at that edge. Returns at next rising edge + 1.
  task automatic step();
    bit e_en;
    int e_addr;
    logic [DW-1:0] e_data;
    #1;
    e_ack_a = 0; e_ack_b = 0; e_en = 0; e_addr = 0; e_data = '0;
    if (m_clearing) begin
      e_en = 1; e_addr = m_clr_addr;
    end else begin
      if (req_a && req_b) begin
`ifdef FILE_REGISTER_RR_EN
        if (m_last_b) e_ack_a = 1; else e_ack_b = 1;
`else
        e_ack_a = 1;
`endif
      end else begin
        e_ack_a = req_a;
        e_ack_b = req_b;
      end
      if (e_ack_a) begin e_addr = int'(addr_a); e_data = data_a; end
      if (e_ack_b) begin e_addr = int'(addr_b); e_data = data_b; end
      e_en = (e_ack_a || e_ack_b) && (e_addr != 0);
    end
    s_ack_a = ack_a; s_ack_b = ack_b; s_wr_en = wr_en; s_busy = busy;
    s_done = clear_done; s_wr_addr = int'(wr_addr);
    check("ack_a", 64'(ack_a), 64'(e_ack_a));
    check("ack_b", 64'(ack_b), 64'(e_ack_b));
    check("wr_en", 64'(wr_en), 64'(e_en));
    check("wr_addr", 64'(wr_addr), 64'(e_addr));
    check("wr_data", 64'(wr_data), 64'(e_data));
    check("busy", 64'(busy), 64'(m_clearing));
    check("clear_done", 64'(clear_done), 64'(m_done));
    $display("[TB] t=%0t rst=%0b ra=%0b rb=%0b clr=%0b ack=%0b%0b en=%0b addr=%0d data=%0h busy=%0b done=%0b",
             $time, reset, req_a, req_b, clear_req, ack_a, ack_b, wr_en, wr_addr, wr_data, busy, clear_done);
    @(negedge clk);
    a_taken = req_a && e_ack_a;
    b_taken = req_b && e_ack_b;
    if (reset) begin
      m_clearing = 0; m_clr_addr = 1; m_done = 0; m_last_b = 1;
    end else begin
      m_done = m_clearing && (m_clr_addr == N - 1);
      if (m_clearing) begin
        if (m_clr_addr == N - 1) begin
          m_clearing = 0; m_clr_addr = 1;
        end else begin
          m_clr_addr++;
        end
      end else begin
        if (e_ack_a) m_last_b = 0;
        if (e_ack_b) m_last_b = 1;
        if (clear_req) m_clearing = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 0; req_b = 0; clear_req = 0; reset = 0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  string grants;

  initial begin
    m_clearing = 0; m_clr_addr = 1; m_done = 0; m_last_b = 1;
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    do_reset();
    step();
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_done", 64'(s_done), 64'd0);

    // Uncontested write from A, zero latency.
    req_a = 1; addr_a = 5'd3; data_a = 32'hDEADBEEF;
    step();
    check("a_ack", 64'(s_ack_a), 64'd1);
    check("a_wr_en", 64'(s_wr_en), 64'd1);
    check("a_wr_addr", 64'(s_wr_addr), 64'd3);
    idle();

    // Write to r0 from B: acked, not written.
    req_b = 1; addr_b = '0; data_b = 32'h5;
    step();
    check("r0_ack_b", 64'(s_ack_b), 64'd1);
    check("r0_wr_en", 64'(s_wr_en), 64'd0);
    idle();

    // Both requesters held for four cycles.
    do_reset();
    req_a = 1; addr_a = 5'd7; data_a = 32'h11;
    req_b = 1; addr_b = 5'd9; data_b = 32'h22;
    grants = "";
    for (int i = 0; i < 4; i++) begin
      step();
      grants = {grants, s_ack_a ? "A" : (s_ack_b ? "B" : "-")};
    end
`ifdef FILE_REGISTER_RR_EN
    check("both_seq", 64'(grants == "ABAB"), 64'd1);
`else
    check("both_seq", 64'(grants == "AAAA"), 64'd1);
`endif
    idle();

    // Full clear sequence.
    clear_req = 1;
    step();
    clear_req = 0;
    for (int i = 1; i < N; i++) begin
      if (i == 5) clear_req = 1;
      step();
      clear_req = 0;
      check("clr_busy", 64'(s_busy), 64'd1);
      check("clr_addr", 64'(s_wr_addr), 64'(i));
    end
    step();
    check("clr_done", 64'(s_done), 64'd1);
    check("clr_idle", 64'(s_busy), 64'd0);
    step();
    check("clr_done_end", 64'(s_done), 64'd0);

    // Reset aborts a clear at pointer 10.
    clear_req = 1;
    step();
    clear_req = 0;
    for (int i = 1; i < 10; i++) step();
    reset = 1;
    step();
    check("abort_addr", 64'(s_wr_addr), 64'd10);
    reset = 0;
    step();
    check("abort_busy", 64'(s_busy), 64'd0);
    check("abort_en", 64'(s_wr_en), 64'd0);
    check("abort_done", 64'(s_done), 64'd0);
    clear_req = 1;
    step();
    clear_req = 0;
    step();
    check("restart_addr", 64'(s_wr_addr), 64'd1);
    do_reset();

    // Randomized traffic; requesters hold until acked.
    a_taken = 0; b_taken = 0;
    for (int c = 0; c < 3000; c++) begin
      if (a_taken) req_a = 0;
      if (b_taken) req_b = 0;
      if (!req_a && ($urandom % 3 == 0)) begin
        req_a = 1;
        addr_a = ($urandom % 8 == 0) ? '0 : AW'($urandom_range(1, N - 1));
        data_a = $urandom;
      end
      if (!req_b && ($urandom % 3 == 0)) begin
        req_b = 1;
        addr_b = ($urandom % 8 == 0) ? '0 : AW'($urandom_range(1, N - 1));
        data_b = $urandom;
      end
      clear_req = ($urandom % 40 == 0);
      reset = ($urandom % 150 == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
